// File: rtl/reg_file_scoreboard_pkg.sv
// rtl/reg_file_scoreboard_pkg.sv - shared constants and port-slice helper for the register file
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_NUM_READ   = 2;
  localparam int ZERO_REG           = 0;

  // Low bit of port k inside a flat vector of width-bit slices
  function automatic int slice_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// rtl/reg_file_scoreboard_if.sv - read/write/reservation bus between pipeline and register file
interface reg_file_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
);

  logic [NUM_READ*ADDR_WIDTH-1:0] ReadID;
  logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
  logic [NUM_READ-1:0]            ReadBusy;
  logic                           EnableWrite;
  logic [ADDR_WIDTH-1:0]          RegIDToWrite;
  logic [DATA_WIDTH-1:0]          DataIn;
  logic                           ReserveEn;
  logic [ADDR_WIDTH-1:0]          ReserveID;
  logic                           Flush;
  logic [ADDR_WIDTH:0]            PendingCount;

  modport master (
    output ReadID, EnableWrite, RegIDToWrite, DataIn, ReserveEn, ReserveID, Flush,
    input  ReadData, ReadBusy, PendingCount
  );

  modport slave (
    input  ReadID, EnableWrite, RegIDToWrite, DataIn, ReserveEn, ReserveID, Flush,
    output ReadData, ReadBusy, PendingCount
  );

endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// rtl/reg_file_scoreboard_sb.sv - busy-bit scoreboard with flush and pending-register counter
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reserve_en,
  input  logic [ADDR_WIDTH-1:0]      reserve_id,
  input  logic                       write_en,
  input  logic [ADDR_WIDTH-1:0]      write_id,
  input  logic                       flush,
  output logic [2**ADDR_WIDTH-1:0]   busy,
  output logic [ADDR_WIDTH:0]        pending_count
);

  logic                     set_hit;
  logic                     clr_hit;
  logic                     inc;
  logic                     dec;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  // A same-edge reservation of the written index supersedes the clear
  always_comb begin
    set_hit   = reserve_en && (reserve_id != ADDR_WIDTH'(ZERO_REG));
    clr_hit   = write_en && (write_id != ADDR_WIDTH'(ZERO_REG)) &&
                !(set_hit && (reserve_id == write_id));
    inc       = set_hit && !busy[reserve_id];
    dec       = clr_hit && busy[write_id];
    busy_next = busy;
    if (clr_hit) busy_next[write_id] = 1'b0;
    if (set_hit) busy_next[reserve_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      pending_count <= '0;
    end else if (flush) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      busy          <= busy_next;
      pending_count <= pending_count + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - multi-read-port register file with busy scoreboard
// Optional write-first read bypass enabled by defining REGFILE_BYPASS_EN.
module reg_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
) (
  input logic                  Clock,
  input logic                  NReset,
  reg_file_scoreboard_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  write_hit;
  logic [ADDR_WIDTH-1:0] id;

  assign write_hit = bus.EnableWrite && (bus.RegIDToWrite != ADDR_WIDTH'(ZERO_REG));

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[bus.RegIDToWrite] <= bus.DataIn;
    end
  end

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk           (Clock),
    .rst_n         (NReset),
    .reserve_en    (bus.ReserveEn),
    .reserve_id    (bus.ReserveID),
    .write_en      (bus.EnableWrite),
    .write_id      (bus.RegIDToWrite),
    .flush         (bus.Flush),
    .busy          (busy),
    .pending_count (bus.PendingCount)
  );

  always_comb begin
    bus.ReadData = '0;
    bus.ReadBusy = '0;
    id           = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      id = bus.ReadID[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      if (id != ADDR_WIDTH'(ZERO_REG)) begin
        bus.ReadData[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = regs[id];
        bus.ReadBusy[k] = busy[id];
      end
`ifdef REGFILE_BYPASS_EN
      // Write-first: the incoming value resolves the operand unless re-reserved this cycle
      if (write_hit && (id == bus.RegIDToWrite)) begin
        bus.ReadData[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] = bus.DataIn;
        bus.ReadBusy[k] = bus.ReserveEn && (bus.ReserveID == id);
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  reg_file_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();

  reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) dut (
    .Clock  (clk),
    .NReset (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [4:0] id);
    bus.ReadID[k*5 +: 5] = id;
  endtask

  function automatic logic [31:0] rd(input int k);
    return bus.ReadData[k*32 +: 32];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ReadID       = '0;
    bus.EnableWrite  = 1'b0;
    bus.RegIDToWrite = '0;
    bus.DataIn       = '0;
    bus.ReserveEn    = 1'b0;
    bus.ReserveID    = '0;
    bus.Flush        = 1'b0;

    // reset state
    set_rd(0, 5); set_rd(1, 31);
    #12;
    check("rst_rd5", rd(0), 0);
    check("rst_rd31", rd(1), 0);
    check("rst_busy", bus.ReadBusy, 0);
    check("rst_cnt", bus.PendingCount, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    set_rd(0, 0);
    #1;
    check("post_rst_rd0", rd(0), 0);
    check("post_rst_busy", bus.ReadBusy, 0);

    // write r8 and ignored write to r0
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 8; bus.DataIn = 32'hDEADBEEF;
    tick();
    bus.RegIDToWrite = 0; bus.DataIn = 32'h12345678;
    tick();
    bus.EnableWrite = 1'b0;
    set_rd(0, 8); set_rd(1, 0);
    #1;
    check("rd_r8", rd(0), 32'hDEADBEEF);
    check("rd_r0", rd(1), 0);

    // reserve r3, then clear with a write
    bus.ReserveEn = 1'b1; bus.ReserveID = 3;
    tick();
    bus.ReserveEn = 1'b0;
    set_rd(0, 3);
    #1;
    check("r3_busy", bus.ReadBusy[0], 1);
    check("r3_cnt", bus.PendingCount, 1);
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 3; bus.DataIn = 32'h55;
    #1;
`ifndef REGFILE_BYPASS_EN
    check("r3_busy_same_cycle", bus.ReadBusy[0], 1);
`else
    check("r3_busy_bypass", bus.ReadBusy[0], 0);
`endif
    tick();
    bus.EnableWrite = 1'b0;
    #1;
    check("r3_clr_busy", bus.ReadBusy[0], 0);
    check("r3_data", rd(0), 32'h55);
    check("r3_clr_cnt", bus.PendingCount, 0);

    // reserve wins over same-edge write
    bus.ReserveEn = 1'b1; bus.ReserveID = 4;
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 4; bus.DataIn = 32'h77;
    tick();
    bus.ReserveEn = 1'b0; bus.EnableWrite = 1'b0;
    set_rd(0, 4);
    #1;
    check("r4_data", rd(0), 32'h77);
    check("r4_busy", bus.ReadBusy[0], 1);
    check("r4_cnt", bus.PendingCount, 1);

    // flush overrides reserve but the register write still lands
    bus.Flush = 1'b1; bus.ReserveEn = 1'b1; bus.ReserveID = 6;
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 10; bus.DataIn = 32'h10;
    tick();
    bus.Flush = 1'b0; bus.ReserveEn = 1'b0; bus.EnableWrite = 1'b0;
    set_rd(0, 6); set_rd(1, 4);
    #1;
    check("flush_busy", bus.ReadBusy, 0);
    check("flush_cnt", bus.PendingCount, 0);
    set_rd(0, 10);
    #1;
    check("flush_write_r10", rd(0), 32'h10);

    // r31 boundary write and read
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 31; bus.DataIn = 32'hFFFFFFFF;
    tick();
    bus.EnableWrite = 1'b0;
    set_rd(1, 31);
    #1;
    check("rd_r31", rd(1), 32'hFFFFFFFF);

    // successive reservations, re-reserve does not nest, write to idle reg keeps count
    bus.ReserveEn = 1'b1;
    bus.ReserveID = 1; tick();
    bus.ReserveID = 2; tick();
    bus.ReserveID = 9; tick();
    bus.ReserveID = 2; tick();
    bus.ReserveEn = 1'b0;
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 12; bus.DataIn = 32'hC;
    tick();
    bus.EnableWrite = 1'b0;
    set_rd(0, 1); set_rd(1, 8);
    #1;
    check("multi_cnt", bus.PendingCount, 3);
    check("multi_busy", bus.ReadBusy, 2'b01);
    check("multi_r8", rd(1), 32'hDEADBEEF);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", bus.PendingCount, 0);
    check("arst_busy", bus.ReadBusy, 0);
    check("arst_r8", rd(1), 0);
    @(negedge clk) rst_n = 1'b1;

    // write-first bypass vs registered read
    bus.EnableWrite = 1'b1; bus.RegIDToWrite = 7; bus.DataIn = 32'h11111111;
    tick();
    set_rd(1, 7);
    bus.DataIn = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rd(1), 32'hA5A5A5A5);
`else
    check("no_bypass_old", rd(1), 32'h11111111);
`endif
    tick();
    bus.EnableWrite = 1'b0;
    #1;
    check("r7_next_cycle", rd(1), 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
